// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract through one CHUNK-wide carry chain, with N/Z/C/V flags.
// Define ADDSUB_SAT_EN to add the sat_signed input, which clamps signed overflows in the result.
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             sat_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    // WIDTH must be an integer multiple of CHUNK.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             zero_q;
    logic [WIDTH-1:0] result_q;
    logic             flagN_q;
    logic             flagZ_q;
    logic             flagC_q;
    logic             flagV_q;
    logic             inReady_q;
    logic             outValid_q;
`ifdef ADDSUB_SAT_EN
    logic             satSigned_q;
`endif

    int               chunkBase;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] sum_d;
    logic             carry_d;
    logic             zero_d;
    logic             overflow_d;
    logic [WIDTH-1:0] satValue;

    // b_q already holds ~b for subtract, so the chunk adder is the same for both ops.
    always_comb begin
        chunkBase  = int'(cnt_q) * CHUNK;
        aChunk     = a_q[chunkBase +: CHUNK];
        bChunk     = b_q[chunkBase +: CHUNK];
        {carry_d, sum_d} = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry_q};
        zero_d     = zero_q & (sum_d == '0);
        overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[CHUNK-1] != a_q[WIDTH-1]);
        satValue   = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            flagN_q     <= 1'b0;
            flagZ_q     <= 1'b0;
            flagC_q     <= 1'b0;
            flagV_q     <= 1'b0;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
`ifdef ADDSUB_SAT_EN
            satSigned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && inReady_q) begin
                        a_q         <= a;
                        b_q         <= sub ? ~b : b;
                        carry_q     <= sub;
                        cnt_q       <= '0;
                        zero_q      <= 1'b1;
                        inReady_q   <= 1'b0;
                        state_q     <= RUN;
`ifdef ADDSUB_SAT_EN
                        satSigned_q <= sat_signed;
`endif
                    end
                end
                RUN: begin
                    result_q[chunkBase +: CHUNK] <= sum_d;
                    carry_q <= carry_d;
                    zero_q  <= zero_d;
                    if (cnt_q == LAST) begin
                        flagC_q    <= carry_d;
                        flagV_q    <= overflow_d;
                        flagN_q    <= sum_d[CHUNK-1];
                        flagZ_q    <= zero_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
`ifdef ADDSUB_SAT_EN
                        if (overflow_d && satSigned_q) begin
                            result_q <= satValue;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef ADDSUB_SAT_EN
    // Without saturation the clamp value has no consumer.
    logic unusedSat;
    assign unusedSat = ^satValue;
`endif

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign flag_n    = flagN_q;
    assign flag_z    = flagZ_q;
    assign flag_c    = flagC_q;
    assign flag_v    = flagV_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vectors with literal expectations plus a cycle-by-cycle arithmetic reference model.
module tb_addsub_seq;

    localparam int NCHUNK = 4;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        satSig = 1'b0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] result;
    logic        flagN, flagZ, flagC, flagV;

    logic        inValid1 = 1'b0;
    logic        inReady1;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic        sub1 = 1'b0;
    logic        outValid1;
    logic        outReady1 = 1'b0;
    logic [31:0] result1;
    logic        flagN1, flagZ1, flagC1, flagV1;

    int numCompared = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_SAT_EN
        .sat_signed(satSig),
`endif
        .out_valid(outValid), .out_ready(outReady), .result(result),
        .flag_n(flagN), .flag_z(flagZ), .flag_c(flagC), .flag_v(flagV)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1), .sub(sub1),
`ifdef ADDSUB_SAT_EN
        .sat_signed(1'b0),
`endif
        .out_valid(outValid1), .out_ready(outReady1), .result(result1),
        .flag_n(flagN1), .flag_z(flagZ1), .flag_c(flagC1), .flag_v(flagV1)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: plain wide arithmetic; returns {n, z, c, v, result}.
    function automatic logic [35:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                             input logic isSub, input logic sat);
        logic [32:0] full;
        logic [31:0] res;
        longint      exact;
        logic        n, z, c, v;
        full  = isSub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        c     = isSub ? (x >= y) : full[32];
        exact = isSub ? (longint'($signed(x)) - longint'($signed(y)))
                      : (longint'($signed(x)) + longint'($signed(y)));
        v     = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        n     = full[31];
        z     = (full[31:0] == 32'd0);
        res   = full[31:0];
        if (SAT_EN && sat && v) res = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        return {n, z, c, v, res};
    endfunction

    logic        ivS = 1'b0;
    logic        orS = 1'b0;
    logic        subS = 1'b0;
    logic        satS = 1'b0;
    logic [31:0] aS = '0;
    logic [31:0] bS = '0;

    always @(negedge clk) begin
        #1;
        ivS  = inValid;
        orS  = outReady;
        subS = sub;
        satS = satSig;
        aS   = a;
        bS   = b;
    end

    int          cyc = 0;
    int          acceptCyc = 0;
    bit          pend = 1'b0;
    bit          modelOv = 1'b0;
    logic [35:0] expVec = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            pend    = 1'b0;
            modelOv = 1'b0;
            checkOutput("rst out_valid", outValid, 0);
            checkOutput("rst in_ready", inReady, 1);
            checkOutput("rst result", result, 0);
            checkOutput("rst flags", {flagN, flagZ, flagC, flagV}, 0);
        end else begin
            if (pend && modelOv && orS) begin
                pend = 1'b0;
            end else if (!pend && ivS) begin
                pend      = 1'b1;
                acceptCyc = cyc;
                expVec    = refModel(aS, bS, subS, satS);
            end
            modelOv = pend && ((cyc - acceptCyc) >= NCHUNK);
            checkOutput("mon out_valid", outValid, modelOv);
            checkOutput("mon in_ready", inReady, !pend);
            if (modelOv && outValid) begin
                checkOutput("mon result", result, expVec[31:0]);
                checkOutput("mon flags", {flagN, flagZ, flagC, flagV}, expVec[35:32]);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] aV, input logic [31:0] bV, input logic subV,
                                 input logic satV, input logic [31:0] expRes, input logic [3:0] expNzcv,
                                 input int hold);
        int lat;
        @(negedge clk);
        inValid = 1'b1; a = aV; b = bV; sub = subV; satSig = satV;
        @(posedge clk); #1;
        checkOutput("in_ready after accept", inReady, 0);
        @(negedge clk);
        inValid = 1'b0; a = ~aV; b = ~bV; sub = ~subV; satSig = ~satV;
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, 4);
        checkOutput("result", result, expRes);
        checkOutput("flags nzcv", {flagN, flagZ, flagC, flagV}, expNzcv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            @(posedge clk); #1;
            checkOutput("hold out_valid", outValid, 1);
            checkOutput("hold in_ready", inReady, 0);
            checkOutput("hold result", result, expRes);
            checkOutput("hold flags", {flagN, flagZ, flagC, flagV}, expNzcv);
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("drain out_valid", outValid, 0);
        checkOutput("drain in_ready", inReady, 1);
        @(negedge clk);
        outReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'd5, 32'd5, 1'b1, 1'b0, 32'd0, 4'b0110, 0);
        applyStimulus(32'd0, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1000, 0);
`ifdef ADDSUB_SAT_EN
        applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1001, 0);
`else
        applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 4'b1001, 0);
`endif
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 4'b0110, 0);
        applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 4'b0000, 5);
        applyStimulus(32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 4'b1001, 0);
        applyStimulus(32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0011, 0);

        // Abort an operation two chunks in; the partial result must vanish at once.
        @(negedge clk);
        inValid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; satSig = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", outValid, 0);
        checkOutput("abort result", result, 0);
        checkOutput("abort in_ready", inReady, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd3, 32'd2, 1'b1, 1'b0, 32'd1, 4'b0010, 0);

        // Single-chunk instance: one RUN cycle.
        @(negedge clk);
        inValid1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd1; sub1 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w32 in_ready after accept", inReady1, 0);
        @(negedge clk);
        inValid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b1;
        lat = 0;
        while (!outValid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("w32 latency", lat, 1);
        checkOutput("w32 result", result1, 32'd0);
        checkOutput("w32 flags nzcv", {flagN1, flagZ1, flagC1, flagV1}, 4'b0110);
        @(negedge clk);
        outReady1 = 1'b1;
        @(posedge clk); #1;
        checkOutput("w32 drain out_valid", outValid1, 0);
        checkOutput("w32 drain in_ready", inReady1, 1);
        @(negedge clk);
        outReady1 = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
